// File: rtl/l2_output_encoder.sv
// L2 outbound encoder: three independent per-channel FIFOs (request, response, invalidation)
// toward the NoC/CPU adapters. Optional macro L2_OUT_BYPASS_EN enables 0-cycle empty-FIFO bypass.
module l2_output_encoder #(
    parameter int DEPTH          = 2,
    parameter int COH_MSG_BITS   = 2,
    parameter int HPROT_BITS     = 1,
    parameter int REQ_ID_BITS    = 3,
    parameter int L2_TAG_BITS    = 12,
    parameter int L2_SET_BITS    = 8,
    parameter int LINE_BITS      = 16,
    parameter int WORD_MASK_BITS = 4,
    localparam int ADDR_W = L2_TAG_BITS + L2_SET_BITS,
    localparam int REQ_W  = COH_MSG_BITS + HPROT_BITS + ADDR_W + LINE_BITS + WORD_MASK_BITS,
    localparam int RSP_W  = COH_MSG_BITS + REQ_ID_BITS + 2 + ADDR_W + LINE_BITS + WORD_MASK_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_send,
    input  logic [REQ_W-1:0]       req_msg,
    output logic                   req_ready,
    input  logic                   rsp_send,
    input  logic [RSP_W-1:0]       rsp_msg,
    output logic                   rsp_ready,
    input  logic                   inv_send,
    input  logic [L2_TAG_BITS-1:0] inv_tag,
    input  logic [L2_SET_BITS-1:0] inv_set,
    output logic                   inv_ready,
    output logic                   l2_req_out_valid_int,
    input  logic                   l2_req_out_ready_int,
    output logic [REQ_W-1:0]       l2_req_out,
    output logic                   l2_rsp_out_valid_int,
    input  logic                   l2_rsp_out_ready_int,
    output logic [RSP_W-1:0]       l2_rsp_out,
    output logic                   l2_inval_valid_int,
    input  logic                   l2_inval_ready_int,
    output logic [ADDR_W-1:0]      l2_inval,
    output logic                   outputs_idle,
    output logic                   overflow
);

    function automatic logic [ADDR_W-1:0] line_addr(input logic [L2_TAG_BITS-1:0] tag,
                                                    input logic [L2_SET_BITS-1:0] set);
        return {tag, set};
    endfunction

    logic [COH_MSG_BITS-1:0]   req_coh, rsp_coh;
    logic [HPROT_BITS-1:0]     req_hprot;
    logic [REQ_ID_BITS-1:0]    rsp_req_id;
    logic [1:0]                rsp_to_req;
    logic [L2_TAG_BITS-1:0]    req_tag, rsp_tag;
    logic [L2_SET_BITS-1:0]    req_set, rsp_set;
    logic [LINE_BITS-1:0]      req_line, rsp_line;
    logic [WORD_MASK_BITS-1:0] req_wm, rsp_wm;
    logic [REQ_W-1:0]          req_enc;
    logic [RSP_W-1:0]          rsp_enc;
    logic [ADDR_W-1:0]         inv_enc;
    logic req_empty, rsp_empty, inv_empty;
    logic req_drop, rsp_drop, inv_drop;

    // Replace each tag/set breakdown with the composed line address (tag in the MSBs).
    assign {req_coh, req_hprot, req_tag, req_set, req_line, req_wm} = req_msg;
    assign {rsp_coh, rsp_req_id, rsp_to_req, rsp_tag, rsp_set, rsp_line, rsp_wm} = rsp_msg;
    assign req_enc = {req_coh, req_hprot, line_addr(req_tag, req_set), req_line, req_wm};
    assign rsp_enc = {rsp_coh, rsp_req_id, rsp_to_req, line_addr(rsp_tag, rsp_set), rsp_line, rsp_wm};
    assign inv_enc = line_addr(inv_tag, inv_set);

    l2_out_fifo #(.DEPTH(DEPTH), .WIDTH(REQ_W)) req_fifo (
        .clk(clk), .rst(rst), .send(req_send), .wdata(req_enc), .ready(req_ready),
        .valid(l2_req_out_valid_int), .ready_int(l2_req_out_ready_int), .rdata(l2_req_out),
        .empty(req_empty), .drop(req_drop)
    );

    l2_out_fifo #(.DEPTH(DEPTH), .WIDTH(RSP_W)) rsp_fifo (
        .clk(clk), .rst(rst), .send(rsp_send), .wdata(rsp_enc), .ready(rsp_ready),
        .valid(l2_rsp_out_valid_int), .ready_int(l2_rsp_out_ready_int), .rdata(l2_rsp_out),
        .empty(rsp_empty), .drop(rsp_drop)
    );

    l2_out_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W)) inv_fifo (
        .clk(clk), .rst(rst), .send(inv_send), .wdata(inv_enc), .ready(inv_ready),
        .valid(l2_inval_valid_int), .ready_int(l2_inval_ready_int), .rdata(l2_inval),
        .empty(inv_empty), .drop(inv_drop)
    );

    assign outputs_idle = req_empty && rsp_empty && inv_empty;

    // Sticky until reset so the FSM can notice a dropped message long after the fact.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (req_drop || rsp_drop || inv_drop) begin
            overflow <= 1'b1;
        end
    end

endmodule

module l2_out_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send,
    input  logic [WIDTH-1:0] wdata,
    output logic             ready,
    output logic             valid,
    input  logic             ready_int,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             drop
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] FULL = (PTR_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
    logic [PTR_BITS:0]   count;
    logic push, pop, stored, bypass, write;

    // Space is judged from the registered count only; a same-cycle pop never makes room.
    assign ready  = (count != FULL);
    assign push   = send && ready;
    assign drop   = send && !ready;
    assign stored = (count != '0);
    assign empty  = !stored;
    assign pop    = stored && ready_int;

`ifdef L2_OUT_BYPASS_EN
    assign bypass = push && !stored && ready_int;
    assign valid  = stored || bypass;
    assign rdata  = stored ? mem[rd_ptr] : (bypass ? wdata : '0);
`else
    assign bypass = 1'b0;
    assign valid  = stored;
    assign rdata  = stored ? mem[rd_ptr] : '0;
`endif

    assign write = push && !bypass;

    always_ff @(posedge clk) begin
        if (write) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_output_encoder.sv
// Table-driven bench for l2_output_encoder (default parameters); expectations adapt when
// L2_OUT_BYPASS_EN is defined for both bench and design.
module tb_l2_output_encoder;

`ifdef L2_OUT_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    localparam int REQ_W = 43;
    localparam int RSP_W = 47;
    localparam int INV_W = 20;

    logic             clk;
    logic             rst;
    logic             req_send, rsp_send, inv_send;
    logic [REQ_W-1:0] req_msg;
    logic [RSP_W-1:0] rsp_msg;
    logic [11:0]      inv_tag;
    logic [7:0]       inv_set;
    logic             req_ready, rsp_ready, inv_ready;
    logic             req_valid, rsp_valid, inv_valid;
    logic             req_rdy_int, rsp_rdy_int, inv_rdy_int;
    logic [REQ_W-1:0] req_out;
    logic [RSP_W-1:0] rsp_out;
    logic [INV_W-1:0] inv_out;
    logic             outputs_idle, overflow;

    int errors = 0;
    int checks = 0;

    l2_output_encoder dut (
        .clk(clk), .rst(rst),
        .req_send(req_send), .req_msg(req_msg), .req_ready(req_ready),
        .rsp_send(rsp_send), .rsp_msg(rsp_msg), .rsp_ready(rsp_ready),
        .inv_send(inv_send), .inv_tag(inv_tag), .inv_set(inv_set), .inv_ready(inv_ready),
        .l2_req_out_valid_int(req_valid), .l2_req_out_ready_int(req_rdy_int), .l2_req_out(req_out),
        .l2_rsp_out_valid_int(rsp_valid), .l2_rsp_out_ready_int(rsp_rdy_int), .l2_rsp_out(rsp_out),
        .l2_inval_valid_int(inv_valid), .l2_inval_ready_int(inv_rdy_int), .l2_inval(inv_out),
        .outputs_idle(outputs_idle), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             req_send;
        logic [REQ_W-1:0] req_msg;
        logic             rsp_send;
        logic [RSP_W-1:0] rsp_msg;
        logic             inv_send;
        logic [11:0]      inv_tag;
        logic [7:0]       inv_set;
        logic             req_rdy_int, rsp_rdy_int, inv_rdy_int;
        logic             e_req_valid;
        logic [REQ_W-1:0] e_req_out;
        logic             e_rsp_valid;
        logic [RSP_W-1:0] e_rsp_out;
        logic             e_inv_valid;
        logic [INV_W-1:0] e_inv_out;
        logic             e_req_ready, e_rsp_ready, e_inv_ready, e_idle, e_ovf;
    } vec_t;

    function automatic logic [REQ_W-1:0] mk_req(input logic [1:0] coh, input logic hprot,
        input logic [11:0] tag, input logic [7:0] set, input logic [15:0] line, input logic [3:0] wm);
        return {coh, hprot, tag, set, line, wm};
    endfunction

    function automatic logic [REQ_W-1:0] mk_req_out(input logic [1:0] coh, input logic hprot,
        input logic [19:0] addr, input logic [15:0] line, input logic [3:0] wm);
        return {coh, hprot, addr, line, wm};
    endfunction

    function automatic logic [RSP_W-1:0] mk_rsp(input logic [1:0] coh, input logic [2:0] id,
        input logic [1:0] to_req, input logic [11:0] tag, input logic [7:0] set,
        input logic [15:0] line, input logic [3:0] wm);
        return {coh, id, to_req, tag, set, line, wm};
    endfunction

    function automatic logic [RSP_W-1:0] mk_rsp_out(input logic [1:0] coh, input logic [2:0] id,
        input logic [1:0] to_req, input logic [19:0] addr, input logic [15:0] line, input logic [3:0] wm);
        return {coh, id, to_req, addr, line, wm};
    endfunction

    function automatic vec_t quiet();
        vec_t v;
        v.req_send = 1'b0; v.req_msg = '0;
        v.rsp_send = 1'b0; v.rsp_msg = '0;
        v.inv_send = 1'b0; v.inv_tag = '0; v.inv_set = '0;
        v.req_rdy_int = 1'b1; v.rsp_rdy_int = 1'b1; v.inv_rdy_int = 1'b1;
        v.e_req_valid = 1'b0; v.e_req_out = '0;
        v.e_rsp_valid = 1'b0; v.e_rsp_out = '0;
        v.e_inv_valid = 1'b0; v.e_inv_out = '0;
        v.e_req_ready = 1'b1; v.e_rsp_ready = 1'b1; v.e_inv_ready = 1'b1;
        v.e_idle = 1'b1; v.e_ovf = 1'b0;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, compare on the falling edge.
    task automatic apply_stimulus(input vec_t v, input int id);
        @(posedge clk);
        #1;
        req_send = v.req_send; req_msg = v.req_msg;
        rsp_send = v.rsp_send; rsp_msg = v.rsp_msg;
        inv_send = v.inv_send; inv_tag = v.inv_tag; inv_set = v.inv_set;
        req_rdy_int = v.req_rdy_int; rsp_rdy_int = v.rsp_rdy_int; inv_rdy_int = v.inv_rdy_int;
        @(negedge clk);
        check_output($sformatf("row%0d req_valid", id), 64'(req_valid), 64'(v.e_req_valid));
        check_output($sformatf("row%0d rsp_valid", id), 64'(rsp_valid), 64'(v.e_rsp_valid));
        check_output($sformatf("row%0d inv_valid", id), 64'(inv_valid), 64'(v.e_inv_valid));
        check_output($sformatf("row%0d req_ready", id), 64'(req_ready), 64'(v.e_req_ready));
        check_output($sformatf("row%0d rsp_ready", id), 64'(rsp_ready), 64'(v.e_rsp_ready));
        check_output($sformatf("row%0d inv_ready", id), 64'(inv_ready), 64'(v.e_inv_ready));
        check_output($sformatf("row%0d outputs_idle", id), 64'(outputs_idle), 64'(v.e_idle));
        check_output($sformatf("row%0d overflow", id), 64'(overflow), 64'(v.e_ovf));
        if (v.e_req_valid) check_output($sformatf("row%0d l2_req_out", id), 64'(req_out), 64'(v.e_req_out));
        if (v.e_rsp_valid) check_output($sformatf("row%0d l2_rsp_out", id), 64'(rsp_out), 64'(v.e_rsp_out));
        if (v.e_inv_valid) check_output($sformatf("row%0d l2_inval", id), 64'(inv_out), 64'(v.e_inv_out));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        req_send = 1'b0; rsp_send = 1'b0; inv_send = 1'b0;
        req_rdy_int = 1'b1; rsp_rdy_int = 1'b1; inv_rdy_int = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        logic [REQ_W-1:0] req_a, req_a_out, req_b, req_b_out;
        logic [RSP_W-1:0] p1, p1_out, p2, p2_out, p3;

        req_a     = mk_req(2'd1, 1'b1, 12'h1A3, 8'h05, 16'hBEEF, 4'hF);
        req_a_out = mk_req_out(2'd1, 1'b1, 20'h1A305, 16'hBEEF, 4'hF);
        req_b     = mk_req(2'd3, 1'b0, 12'h004, 8'hFF, 16'h0001, 4'h2);
        req_b_out = mk_req_out(2'd3, 1'b0, 20'h004FF, 16'h0001, 4'h2);
        p1        = mk_rsp(2'd2, 3'd1, 2'd1, 12'h111, 8'h22, 16'h1234, 4'h3);
        p1_out    = mk_rsp_out(2'd2, 3'd1, 2'd1, 20'h11122, 16'h1234, 4'h3);
        p2        = mk_rsp(2'd3, 3'd5, 2'd2, 12'hABC, 8'hDE, 16'h5678, 4'hC);
        p2_out    = mk_rsp_out(2'd3, 3'd5, 2'd2, 20'hABCDE, 16'h5678, 4'hC);
        p3        = mk_rsp(2'd1, 3'd7, 2'd3, 12'hFFF, 8'h00, 16'h9ABC, 4'h1);

        // Rows 0-3: reset state and a single request; rows 4-9: response FIFO overflow.
        tbl[0] = quiet();
        v = quiet(); v.req_send = 1'b1; v.req_msg = req_a;
        v.e_req_valid = BYP; v.e_req_out = req_a_out; tbl[1] = v;
        v = quiet(); v.e_req_valid = !BYP; v.e_req_out = req_a_out; v.e_idle = BYP; tbl[2] = v;
        tbl[3] = quiet();
        v = quiet(); v.rsp_send = 1'b1; v.rsp_msg = p1; v.rsp_rdy_int = 1'b0; tbl[4] = v;
        v = quiet(); v.rsp_send = 1'b1; v.rsp_msg = p2; v.rsp_rdy_int = 1'b0;
        v.e_rsp_valid = 1'b1; v.e_rsp_out = p1_out; v.e_idle = 1'b0; tbl[5] = v;
        v = quiet(); v.rsp_send = 1'b1; v.rsp_msg = p3; v.rsp_rdy_int = 1'b0;
        v.e_rsp_valid = 1'b1; v.e_rsp_out = p1_out; v.e_rsp_ready = 1'b0; v.e_idle = 1'b0; tbl[6] = v;
        v = quiet(); v.e_rsp_valid = 1'b1; v.e_rsp_out = p1_out; v.e_rsp_ready = 1'b0;
        v.e_idle = 1'b0; v.e_ovf = 1'b1; tbl[7] = v;
        v = quiet(); v.e_rsp_valid = 1'b1; v.e_rsp_out = p2_out; v.e_idle = 1'b0; v.e_ovf = 1'b1; tbl[8] = v;
        v = quiet(); v.e_ovf = 1'b1; tbl[9] = v;

        rst = 1'b0;
        req_send = 1'b0; rsp_send = 1'b0; inv_send = 1'b0;
        req_msg = '0; rsp_msg = '0; inv_tag = '0; inv_set = '0;
        req_rdy_int = 1'b1; rsp_rdy_int = 1'b1; inv_rdy_int = 1'b1;
        #1;
        check_output("reset req_valid", 64'(req_valid), 64'd0);
        check_output("reset outputs_idle", 64'(outputs_idle), 64'd1);
        check_output("reset req_out", 64'(req_out), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(tbl[i], i);
        end

        // Full invalidation FIFO: a send during a pop is still rejected.
        do_reset();
        apply_stimulus(quiet(), 100);
        v = quiet(); v.inv_send = 1'b1; v.inv_tag = 12'h321; v.inv_set = 8'h54; v.inv_rdy_int = 1'b0;
        apply_stimulus(v, 101);
        v = quiet(); v.inv_send = 1'b1; v.inv_tag = 12'h0F0; v.inv_set = 8'hA5; v.inv_rdy_int = 1'b0;
        v.e_inv_valid = 1'b1; v.e_inv_out = 20'h32154; v.e_idle = 1'b0;
        apply_stimulus(v, 102);
        v = quiet(); v.inv_send = 1'b1; v.inv_tag = 12'h777; v.inv_set = 8'h77;
        v.e_inv_valid = 1'b1; v.e_inv_out = 20'h32154; v.e_inv_ready = 1'b0; v.e_idle = 1'b0;
        apply_stimulus(v, 103);
        v = quiet(); v.e_inv_valid = 1'b1; v.e_inv_out = 20'h0F0A5; v.e_idle = 1'b0; v.e_ovf = 1'b1;
        apply_stimulus(v, 104);
        v = quiet(); v.e_ovf = 1'b1;
        apply_stimulus(v, 105);

        // Concurrent sends on all three channels.
        do_reset();
        v = quiet(); v.req_send = 1'b1; v.req_msg = req_b; v.rsp_send = 1'b1; v.rsp_msg = p2;
        v.inv_send = 1'b1; v.inv_tag = 12'h321; v.inv_set = 8'h54;
        v.e_req_valid = BYP; v.e_req_out = req_b_out; v.e_rsp_valid = BYP; v.e_rsp_out = p2_out;
        v.e_inv_valid = BYP; v.e_inv_out = 20'h32154;
        apply_stimulus(v, 110);
        v = quiet(); v.e_req_valid = !BYP; v.e_req_out = req_b_out; v.e_rsp_valid = !BYP;
        v.e_rsp_out = p2_out; v.e_inv_valid = !BYP; v.e_inv_out = 20'h32154; v.e_idle = BYP;
        apply_stimulus(v, 111);
        apply_stimulus(quiet(), 112);

        // Simultaneous push and pop at count 1 keeps order.
        v = quiet(); v.rsp_send = 1'b1; v.rsp_msg = p1; v.rsp_rdy_int = 1'b0;
        apply_stimulus(v, 120);
        v = quiet(); v.rsp_send = 1'b1; v.rsp_msg = p2;
        v.e_rsp_valid = 1'b1; v.e_rsp_out = p1_out; v.e_idle = 1'b0;
        apply_stimulus(v, 121);
        v = quiet(); v.e_rsp_valid = 1'b1; v.e_rsp_out = p2_out; v.e_idle = 1'b0;
        apply_stimulus(v, 122);
        apply_stimulus(quiet(), 123);

        // Asynchronous reset while a request is pending.
        v = quiet(); v.req_send = 1'b1; v.req_msg = req_a; v.req_rdy_int = 1'b0;
        apply_stimulus(v, 130);
        v = quiet(); v.req_rdy_int = 1'b0; v.e_req_valid = 1'b1; v.e_req_out = req_a_out; v.e_idle = 1'b0;
        apply_stimulus(v, 131);
        #2;
        rst = 1'b0;
        #1;
        check_output("async reset req_valid", 64'(req_valid), 64'd0);
        check_output("async reset outputs_idle", 64'(outputs_idle), 64'd1);
        check_output("async reset req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply_stimulus(quiet(), 132);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
